stepper_sequencer: RTL and testbench
====================================

# stepper_sequencer

Turns a move command (step count, direction, step period) into a full-step, two-phase-on coil sequence for a unipolar stepper motor. Steps are paced by the existing `timer` block, which sits directly downstream. This block drives the timer's `start` and `count` and consumes its `done`. It also tracks absolute motor position and supports a clean abort at step boundaries.

## Interface
Parameters:
- `STEP_W`, default 16: width of the step-count field.
- `PERIOD_W`, default 32: width of the step-period field; matches the timer `count` (int unsigned).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  a move command is presented.
- `cmd_ready`  out  1  the block accepts a command this cycle; high only in IDLE.
- `cmd_steps`  in  STEP_W  number of steps to take.
- `cmd_dir`  in  1  direction: 1 increments the phase index and position, 0 decrements them.
- `cmd_period`  in  PERIOD_W  value driven to the timer `count`.
- `abort`  in  1  level; request termination of the move in progress.
- `timer_start`  out  1  connects to timer `start`.
- `timer_count`  out  PERIOD_W  connects to timer `count`; holds the latched `cmd_period`.
- `timer_done`  in  1  connects to timer `done`.
- `coils`  out  4  coil drive pattern.
- `position`  out  32  signed absolute step position.
- `busy`  out  1  high in any state other than IDLE.
- `move_done`  out  1  one-cycle pulse when a move finishes or is aborted.
- `move_aborted`  out  1  one-cycle pulse, coincident with `move_done`, only when the move ended by abort.

## Operation
- Accept a command when `cmd_valid && cmd_ready`:
  - Latch steps, direction and period.
  - If steps = 0, pulse `move_done` next cycle and stay in IDLE; `timer_start` is never asserted.
  - Otherwise go to ARM.
- Phase index is 2 bits and wraps modulo 4. Coil pattern by phase: 0 = 0011, 1 = 0110, 2 = 1100, 3 = 1001. Coils hold their pattern when idle, to keep holding torque.
- State machine, with `timer_start` a Moore output (high in ARM only):
  - IDLE: `cmd_ready` = 1. Leaves on acceptance of a nonzero-step command.
  - ARM: `timer_start` = 1; wait for `timer_done` = 1, then go to STEP.
  - STEP (one cycle):
    - If no abort is pending: advance the phase by ±1, update `position` by ±1, decrement remaining.
    - If abort is pending: make no step and clear remaining.
    - Then go to RELEASE.
  - RELEASE: `timer_start` = 0; wait for `timer_done` = 0.
    - If remaining = 0, go to IDLE and pulse `move_done` (plus `move_aborted` if the move was aborted).
    - Otherwise go back to ARM.
- Abort:
  - `abort` sampled high in any non-IDLE state sets `abort_pend`.
  - It takes effect only at the next STEP, so the timer handshake always completes.
  - `abort_pend` is cleared on return to IDLE.
  - `abort` in IDLE is ignored.
- Arithmetic:
  - `position` wraps in two's complement at ±2^31.
  - Remaining is STEP_W bits and never underflows, because a step is taken only when remaining > 0.

## Timing
- Reset values: `coils` = 0011, phase 0, `position` = 0, `cmd_ready` = 1, `busy` = 0, `timer_start` = 0, `timer_count` = 0, `move_done` = 0, `move_aborted` = 0, state IDLE.
- Reset mid-move returns every output to its reset value immediately (asynchronously), with no `move_done` pulse.
- The latched command is registered, so the first ARM cycle is the cycle after acceptance.
- With the timer attached and period P:
  - `timer_done` is first seen P+2 cycles after ARM entry.
  - `coils` change at the start of cycle P+4 relative to ARM entry.
  - Successive coil changes are exactly P+5 cycles apart.
- `move_done` is high for the single cycle in which the state first reads IDLE again; `cmd_ready` is also high that cycle.
- Abort latency is at most P+5 cycles.

## Structure
- Package `stepper_pkg`:
  - `stepper_state_t` enum (IDLE, ARM, STEP, RELEASE).
  - `COIL_LUT` constant (4 × 4-bit).
  - `POS_W` = 32.
- No sub-module. The phase-to-coil lookup is a `COIL_LUT` index.
- `timer` is instantiated beside this block at the top level, not inside it.

## Test plan
All scenarios run with a real `timer` attached.
1. Reset -> `coils` = 0011, `position` = 0, `cmd_ready` = 1, `busy`/`timer_start`/`move_done` = 0; repeating reset mid-move gives the same values.
2. steps = 3, dir = 1, period = 10 -> `coils` 0110, 1100, 1001 at 15-cycle spacing; `position` = 3; exactly one `move_done` pulse, with `move_aborted` = 0.
3. steps = 5, dir = 0, period = 2, from phase 0 -> `coils` 1001, 1100, 0110, 0011, 1001 at 7-cycle spacing; `position` = −5.
4. steps = 0 -> `move_done` on the next cycle; `timer_start` never rises; `position` and `coils` unchanged.
5. steps = 100, period = 4, `abort` pulsed for one cycle 20 cycles after acceptance:
   - no coil change after the abort takes effect;
   - `move_done` and `move_aborted` pulse together;
   - `position` = number of coil changes observed (2);
   - the next command is accepted normally.
6. Back-to-back commands with `cmd_valid` held high -> the second command is accepted in the `move_done` cycle; `position` accumulates across both moves.

Source files
------------

// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state type and constants for the stepper sequencer
package stepper_pkg;

   typedef enum logic [1:0] {IDLE, ARM, STEP, RELEASE} stepper_state_t;

   // Two-phase-on full-step patterns, indexed by phase 0..3
   localparam logic [3:0][3:0] COIL_LUT = {4'b1001, 4'b1100, 4'b0110, 4'b0011};

   localparam int POS_W = 32;

endpackage

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: paces full-step coil phases from timer handshakes and tracks position
module stepper_sequencer
   import stepper_pkg::*;
#(
   parameter int STEP_W   = 16,
   parameter int PERIOD_W = 32
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [STEP_W-1:0]   cmd_steps,
   input  logic                cmd_dir,
   input  logic [PERIOD_W-1:0] cmd_period,
   input  logic                abort,
   output logic                timer_start,
   output logic [PERIOD_W-1:0] timer_count,
   input  logic                timer_done,
   output logic [3:0]          coils,
   output logic [POS_W-1:0]    position,
   output logic                busy,
   output logic                move_done,
   output logic                move_aborted
);

   stepper_state_t      state_q;
   logic [1:0]          phase_q;
   logic [STEP_W-1:0]   rem_q;
   logic [PERIOD_W-1:0] period_q;
   logic [POS_W-1:0]    pos_q;
   logic                dir_q;
   logic                abort_pend_q;
   logic                aborted_q;
   logic                done_q;
   logic                aborted_pulse_q;
   logic                abort_now;

   // An abort raised in the STEP cycle itself still counts for that step
   assign abort_now    = abort_pend_q | abort;
   assign cmd_ready    = state_q == IDLE;
   assign busy         = state_q != IDLE;
   assign timer_start  = state_q == ARM;
   assign timer_count  = period_q;
   assign coils        = COIL_LUT[phase_q];
   assign position     = pos_q;
   assign move_done    = done_q;
   assign move_aborted = aborted_pulse_q;

   // Move FSM: accept, arm timer, step on done, wait for done to drop, repeat
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q         <= IDLE;
         phase_q         <= 2'd0;
         rem_q           <= '0;
         period_q        <= '0;
         pos_q           <= '0;
         dir_q           <= 1'b0;
         abort_pend_q    <= 1'b0;
         aborted_q       <= 1'b0;
         done_q          <= 1'b0;
         aborted_pulse_q <= 1'b0;
      end else begin
         done_q          <= 1'b0;
         aborted_pulse_q <= 1'b0;
         if (state_q != IDLE && abort) abort_pend_q <= 1'b1;
         case (state_q)
            IDLE: if (cmd_valid) begin
               rem_q     <= cmd_steps;
               dir_q     <= cmd_dir;
               period_q  <= cmd_period;
               aborted_q <= 1'b0;
               if (cmd_steps == '0) done_q <= 1'b1;
               else state_q <= ARM;
            end
            ARM: if (timer_done) state_q <= STEP;
            STEP: begin
               if (abort_now) begin
                  rem_q     <= '0;
                  aborted_q <= 1'b1;
               end else begin
                  phase_q <= dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
                  pos_q   <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                  rem_q   <= rem_q - STEP_W'(1);
               end
               state_q <= RELEASE;
            end
            RELEASE: if (!timer_done) begin
               if (rem_q == '0) begin
                  state_q         <= IDLE;
                  done_q          <= 1'b1;
                  aborted_pulse_q <= aborted_q;
                  abort_pend_q    <= 1'b0;
               end else begin
                  state_q <= ARM;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: directed checks of the sequencer driving a behavioural timer
module tb_stepper_sequencer;

   logic        clk;
   logic        n_reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_steps;
   logic        cmd_dir;
   logic [31:0] cmd_period;
   logic        abort;
   logic        timer_start;
   logic [31:0] timer_count;
   logic        timer_done;
   logic [3:0]  coils;
   logic [31:0] position;
   logic        busy;
   logic        move_done;
   logic        move_aborted;

   longint      tcnt;
   int          cyc;
   int          pass_cnt;
   int          total_cnt;
   int          done_cnt;
   int          ab_cnt;
   int          split_cnt;
   int          start_cnt;
   int          done_cyc;
   int          base;
   int          da;
   int          chg_cyc[$];
   logic [3:0]  chg_val[$];
   logic [3:0]  prev_coils;

   stepper_sequencer dut (
      .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period), .abort(abort),
      .timer_start(timer_start), .timer_count(timer_count), .timer_done(timer_done),
      .coils(coils), .position(position), .busy(busy), .move_done(move_done),
      .move_aborted(move_aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timer: done rises P+2 cycles after start rises and follows start back down
   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         tcnt       <= 0;
         timer_done <= 1'b0;
      end else begin
         timer_done <= timer_start && (tcnt >= longint'(timer_count) + 1);
         tcnt       <= timer_start ? tcnt + 1 : 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (coils !== prev_coils) begin
         chg_cyc.push_back(cyc);
         chg_val.push_back(coils);
      end
      prev_coils = coils;
      if (move_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (move_aborted) ab_cnt++;
      if (move_aborted && !move_done) split_cnt++;
      if (timer_start) start_cnt++;
   endtask

   task automatic clear_log();
      chg_cyc.delete();
      chg_val.delete();
      done_cnt  = 0;
      ab_cnt    = 0;
      split_cnt = 0;
      start_cnt = 0;
      done_cyc  = -1;
   endtask

   task automatic do_reset();
      n_reset   = 1'b0;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      repeat (2) @(negedge clk);
      n_reset    = 1'b1;
      prev_coils = coils;
   endtask

   task automatic run_move(input int steps, input logic d, input int p, input int abort_cyc,
                           output int b);
      clear_log();
      cmd_steps  = 16'(steps);
      cmd_dir    = d;
      cmd_period = 32'(p);
      cmd_valid  = 1'b1;
      b          = cyc;
      tick();
      cmd_valid = 1'b0;
      for (int i = 1; i < 3000 && done_cnt == 0; i++) begin
         abort = (i == abort_cyc);
         tick();
      end
      abort = 1'b0;
   endtask

   task automatic check_changes(input string tag, input int b, input int gap,
                                input logic [3:0] v [5], input int n);
      check({tag, "_nchg"}, chg_cyc.size(), n);
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s_t%0d", tag, k), chg_cyc[k] - b, gap * (k + 1));
         check($sformatf("%s_v%0d", tag, k), chg_val[k], v[k]);
      end
   endtask

   initial begin
      logic [3:0] seq [5];
      cyc = 0; pass_cnt = 0; total_cnt = 0;
      cmd_steps = '0; cmd_dir = 1'b0; cmd_period = '0;
      clear_log();
      do_reset();

      check("rst_coils", coils, 4'b0011);
      check("rst_pos", position, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_tstart", timer_start, 0);
      check("rst_tcount", timer_count, 0);
      check("rst_done", move_done, 0);
      check("rst_abort", move_aborted, 0);

      // Mid-move reset
      clear_log();
      cmd_steps = 16'd4; cmd_dir = 1'b1; cmd_period = 32'd3; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("mid_busy", busy, 1);
      check("mid_ready", cmd_ready, 0);
      check("mid_tstart", timer_start, 1);
      check("mid_tcount", timer_count, 3);
      repeat (12) tick();
      check("mid_coils", coils, 4'b0110);
      check("mid_pos", position, 1);
      #2 n_reset = 1'b0;
      #1;
      check("mrst_coils", coils, 4'b0011);
      check("mrst_pos", position, 0);
      check("mrst_ready", cmd_ready, 1);
      check("mrst_busy", busy, 0);
      check("mrst_tstart", timer_start, 0);
      check("mrst_tcount", timer_count, 0);
      repeat (2) tick();
      n_reset = 1'b1;
      tick();
      check("mrst_nodone", done_cnt, 0);

      // 3 steps up, period 10
      do_reset();
      run_move(3, 1'b1, 10, -1, base);
      seq = '{4'b0110, 4'b1100, 4'b1001, 4'b0000, 4'b0000};
      check_changes("up3", base, 15, seq, 3);
      check("up3_ndone", done_cnt, 1);
      check("up3_tdone", done_cyc - base, 46);
      check("up3_abort", ab_cnt, 0);
      check("up3_pos", position, 3);
      check("up3_ready", cmd_ready, 1);

      // 5 steps down, period 2, from phase 0
      do_reset();
      run_move(5, 1'b0, 2, -1, base);
      seq = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001};
      check_changes("dn5", base, 7, seq, 5);
      check("dn5_tdone", done_cyc - base, 36);
      check("dn5_pos", position, -5);

      // Zero-step command
      run_move(0, 1'b1, 7, -1, base);
      check("zero_tdone", done_cyc - base, 1);
      check("zero_ready", cmd_ready, 1);
      check("zero_start", start_cnt, 0);
      check("zero_nchg", chg_cyc.size(), 0);
      check("zero_pos", position, -5);
      check("zero_coils", coils, 4'b1001);

      // Abort during a long move
      do_reset();
      run_move(100, 1'b1, 4, 20, base);
      check("ab_nchg", chg_cyc.size(), 2);
      check("ab_last", chg_cyc[1] - base, 18);
      check("ab_tdone", done_cyc - base, 28);
      check("ab_ndone", done_cnt, 1);
      check("ab_flag", ab_cnt, 1);
      check("ab_split", split_cnt, 0);
      check("ab_pos", position, 2);
      check("ab_coils", coils, 4'b1100);
      run_move(1, 1'b1, 0, -1, base);
      check("after_tdone", done_cyc - base, 6);
      check("after_abort", ab_cnt, 0);
      check("after_pos", position, 3);
      check("after_coils", coils, 4'b1001);

      // Back-to-back with cmd_valid held
      do_reset();
      clear_log();
      cmd_steps = 16'd2; cmd_dir = 1'b1; cmd_period = 32'd1; cmd_valid = 1'b1;
      base = cyc;
      for (int i = 0; i < 500 && done_cnt == 0; i++) tick();
      da = done_cyc;
      check("b2b_tdone1", da - base, 13);
      check("b2b_ready", cmd_ready, 1);
      check("b2b_pos1", position, 2);
      cmd_steps = 16'd3;
      tick();
      cmd_valid = 1'b0;
      check("b2b_busy", busy, 1);
      for (int i = 0; i < 500 && done_cnt < 2; i++) tick();
      check("b2b_ndone", done_cnt, 2);
      check("b2b_tdone2", done_cyc - da, 19);
      check("b2b_pos2", position, 5);
      check("b2b_coils", coils, 4'b0110);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
